// File: rtl/kid_move_ctrl.sv
// Per-frame kid movement controller: walks the kid one pixel at a time, waits for the
// collision detector to settle after each step, and handles jump, gravity and fall-out respawn.
module kid_move_ctrl #(
    parameter int KID_W   = 20,
    parameter int KID_H   = 21,
    parameter int SPAWN_X = 40,
    parameter int SPAWN_Y = 557,
    parameter int H_SPEED = 3,
    parameter int JUMP_V  = 8,
    parameter int VMAX    = 8,
    parameter int KILL_Y  = 599
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       left,
    input  logic       right,
    input  logic       jump,
    input  logic [3:0] is_collide,
    output logic [9:0] kid_t,
    output logic [9:0] kid_b,
    output logic [9:0] kid_l,
    output logic [9:0] kid_r,
    output logic       on_ground,
    output logic       busy,
    output logic       done,
    output logic       fell,
    output logic       overrun
);

    typedef enum logic [2:0] {IDLE, H_SETTLE, H_CHK, V_SETTLE, V_CHK, FIN} state_t;

    localparam logic [9:0]        SPAWN_L = 10'(SPAWN_X);
    localparam logic [9:0]        SPAWN_T = 10'(SPAWN_Y);
    localparam logic [9:0]        W10     = 10'(KID_W);
    localparam logic [9:0]        H10     = 10'(KID_H);
    localparam logic [9:0]        KILL_B  = 10'(KILL_Y);
    localparam logic [9:0]        X_MAX   = 10'd799;
    localparam logic signed [4:0] JUMP_S  = 5'(JUMP_V);
    localparam logic signed [4:0] VMAX_S  = 5'(VMAX);
    localparam logic signed [4:0] HSPD_S  = 5'(H_SPEED);

    state_t            state, state_n;
    logic [9:0]        kid_l_n, kid_t_n;
    logic signed [4:0] vy, vy_n, dx, dx_n;
    logic [4:0]        vcnt, vcnt_n;
    logic              jump_d, jump_pend, jump_pend_n;
    logic              fall, fall_n, og_n, done_n, fell_n, overrun_n;

    // Gravity step saturating at the terminal fall speed.
    function automatic logic signed [4:0] vy_gravity(input logic signed [4:0] v);
        if (v >= VMAX_S) return VMAX_S;
        return v + 5'sd1;
    endfunction

    function automatic logic [4:0] vy_mag(input logic signed [4:0] v);
        return v[4] ? 5'(-v) : 5'(v);
    endfunction

    always_comb begin
        state_n     = state;
        kid_l_n     = kid_l;
        kid_t_n     = kid_t;
        vy_n        = vy;
        dx_n        = dx;
        vcnt_n      = vcnt;
        fall_n      = fall;
        og_n        = on_ground;
        done_n      = 1'b0;
        fell_n      = 1'b0;
        jump_pend_n = jump_pend | (jump & ~jump_d);
        overrun_n   = frame_tick && (state != IDLE);
        case (state)
            IDLE: begin
                if (frame_tick) begin
                    if (left && !right)      dx_n = -HSPD_S;
                    else if (right && !left) dx_n = HSPD_S;
                    else                     dx_n = '0;
                    // A jump edge arriving on the tick cycle itself still counts.
                    vy_n        = (jump_pend_n && on_ground) ? -JUMP_S : vy_gravity(vy);
                    jump_pend_n = 1'b0;
                    fall_n      = 1'b0;
                    state_n     = H_SETTLE;
                end
            end
            H_SETTLE: state_n = H_CHK;
            H_CHK: begin
                state_n = V_SETTLE;
                vcnt_n  = vy_mag(vy);
                if (dx < 0) begin
                    if (is_collide[1] || kid_l == 10'd0) dx_n = '0;
                    else begin
                        kid_l_n = kid_l - 10'd1;
                        dx_n    = dx + 5'sd1;
                        state_n = H_SETTLE;
                    end
                end else if (dx > 0) begin
                    if (is_collide[0] || kid_r == X_MAX) dx_n = '0;
                    else begin
                        kid_l_n = kid_l + 10'd1;
                        dx_n    = dx - 5'sd1;
                        state_n = H_SETTLE;
                    end
                end
            end
            V_SETTLE: state_n = V_CHK;
            V_CHK: begin
                state_n = FIN;
                if (vy < 0) begin
                    if (is_collide[3] || kid_t == 10'd0) vy_n = '0;
                    else begin
                        kid_t_n = kid_t - 10'd1;
                        vcnt_n  = vcnt - 5'd1;
                        if (vcnt_n != 5'd0) state_n = V_SETTLE;
                    end
                end else if (vy > 0) begin
                    if (is_collide[2]) vy_n = '0;
                    else begin
                        kid_t_n = kid_t + 10'd1;
                        vcnt_n  = vcnt - 5'd1;
                        if (kid_t_n + H10 == KILL_B) fall_n = 1'b1;
                        else if (vcnt_n != 5'd0)     state_n = V_SETTLE;
                    end
                end
            end
            FIN: begin
                og_n    = is_collide[2];
                done_n  = 1'b1;
                state_n = IDLE;
                if (fall) begin
                    fell_n  = 1'b1;
                    kid_l_n = SPAWN_L;
                    kid_t_n = SPAWN_T;
                    vy_n    = '0;
                    fall_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Edge-derived outputs are computed from next-state values so kid_r/kid_b track kid_l/kid_t.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            kid_l     <= SPAWN_L;
            kid_t     <= SPAWN_T;
            kid_r     <= SPAWN_L + W10;
            kid_b     <= SPAWN_T + H10;
            vy        <= '0;
            dx        <= '0;
            vcnt      <= '0;
            jump_d    <= 1'b0;
            jump_pend <= 1'b0;
            fall      <= 1'b0;
            on_ground <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fell      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_n;
            kid_l     <= kid_l_n;
            kid_t     <= kid_t_n;
            kid_r     <= kid_l_n + W10;
            kid_b     <= kid_t_n + H10;
            vy        <= vy_n;
            dx        <= dx_n;
            vcnt      <= vcnt_n;
            jump_d    <= jump;
            jump_pend <= jump_pend_n;
            fall      <= fall_n;
            on_ground <= og_n;
            busy      <= (state_n != IDLE);
            done      <= done_n;
            fell      <= fell_n;
            overrun   <= overrun_n;
        end
    end

endmodule

// File: doc/kid_move_ctrl.md
KID_MOVE_CTRL -- requirements
Module: kid_move_ctrl

Interface
REQ-001 SHALL have parameter KID_W, default 20, meaning the kid hitbox width in pixels (kid_r = kid_l + KID_W).
REQ-002 SHALL have parameter KID_H, default 21, meaning the kid hitbox height in pixels (kid_b = kid_t + KID_H).
REQ-003 SHALL have parameter SPAWN_X, default 40, meaning the reset and respawn kid_l.
REQ-004 SHALL have parameter SPAWN_Y, default 557, meaning the reset and respawn kid_t.
REQ-005 SHALL have parameter H_SPEED, default 3, meaning the horizontal pixels requested per frame.
REQ-006 SHALL have parameter JUMP_V, default 8, meaning the upward speed applied at jump.
REQ-007 SHALL have parameter VMAX, default 8, meaning the maximum fall speed.
REQ-008 SHALL have parameter KILL_Y, default 599, meaning the kid_b value that triggers a fall-out.
REQ-009 SHALL have ports: clk in 1 system clock; rst_n in 1 reset; frame_tick in 1 one-cycle frame strobe; left in 1 level; right in 1 level; jump in 1 level.
REQ-010 SHALL have port is_collide in 4, carrying the collision detector flags {top, bottom, left, right}.
REQ-011 SHALL have outputs kid_t, kid_b, kid_l and kid_r, each out 10, driving the collision detector.
REQ-012 SHALL have outputs on_ground out 1, busy out 1, done out 1 (pulse), fell out 1 (pulse) and overrun out 1 (pulse).
REQ-013 SHALL use one clock; reset is asynchronous and active-low (clk, rst_n).

Function
REQ-014 SHALL treat is_collide as valid at the second rising clk edge after kid_t/kid_b/kid_l/kid_r change, because the detector samples on negedge.
- Every single-pixel move SHALL be followed by exactly one SETTLE cycle before is_collide is evaluated.
REQ-015 SHALL implement the FSM IDLE -> H_SETTLE -> H_CHK -> V_SETTLE -> V_CHK -> FIN -> IDLE.
- busy SHALL be 1 in every state except IDLE.
REQ-016 In IDLE, on frame_tick, the block SHALL:
- set dx: left only = -H_SPEED; right only = +H_SPEED; both or neither = 0;
- update vy: if a jump is pending and on_ground = 1, vy = -JUMP_V; else vy = min(vy+1, VMAX);
- clear the pending jump;
- enter H_SETTLE.
REQ-017 SHALL latch a rising edge of jump into a pending-jump flag at any time; the flag is cleared only at frame start.
REQ-018 In H_CHK, if |dx| = 0, SHALL go to V_SETTLE.
- If moving left and (is_collide[1] or kid_l = 0), SHALL set dx = 0 and go to V_SETTLE.
- If moving right and (is_collide[0] or kid_r = 799), SHALL set dx = 0 and go to V_SETTLE.
- Otherwise SHALL move kid_l 1 px toward dx, decrement |dx| and go to H_SETTLE.
REQ-019 In V_CHK, moving up (vy<0): if is_collide[3] or kid_t = 0, SHALL set vy = 0 and go to FIN; else SHALL set kid_t -= 1, decrement the remaining count and go to V_SETTLE.
REQ-020 In V_CHK, moving down (vy>0): if is_collide[2], SHALL set vy = 0 and go to FIN.
- Otherwise SHALL set kid_t += 1 and decrement the remaining count.
- If the new kid_b = KILL_Y, SHALL go to FIN with a fall flag; else SHALL go to V_SETTLE.
- If vy = 0 or the remaining count = 0, SHALL go to FIN.
REQ-021 SHALL load the vertical remaining count with |vy| on entry to V_SETTLE from H_CHK.
REQ-022 In FIN, SHALL set on_ground = is_collide[2] (position settled) and pulse done for 1 cycle.
- If the fall flag is set, SHALL additionally pulse fell and reload kid_l = SPAWN_X, kid_t = SPAWN_Y, vy = 0.
- SHALL then go to IDLE.
REQ-023 SHALL ignore a frame_tick while busy = 1 and pulse overrun for 1 cycle; the frame in progress SHALL be unaffected.
REQ-024 SHALL hold vy as a signed 5-bit value, SHALL keep kid_l/kid_t as unsigned 10-bit values, and SHALL never wrap kid_l/kid_t; this is enforced by the REQ-018/019 limits.
REQ-025 SHALL register all outputs; kid_r and kid_b SHALL update in the same cycle as kid_l and kid_t.

Reset
REQ-026 On rst_n = 0, at any time including mid-frame, the block SHALL immediately set:
- kid_l = SPAWN_X, kid_t = SPAWN_Y (kid_r = 60, kid_b = 578);
- vy = 0, dx = 0;
- on_ground = 0, busy = 0, done = 0, fell = 0, overrun = 0;
- pending jump cleared;
- state IDLE.
REQ-027 After rst_n rises, the first frame_tick SHALL be processed normally.

Verification
REQ-028 Idle fall: detector model reports bottom at kid_b = 578; frame_tick with no input -> vy = 1, kid_t stays 557, on_ground = 1 in FIN, done pulses once.
REQ-029 Walk right: right = 1 in open space for one frame -> kid_l = 43 and done pulses; right blocked at kid_r = 62 -> kid_l stops at 42 with no further movement.
REQ-030 Jump: on_ground = 1 and a jump edge before frame_tick -> kid_t decreases 8 px in that frame; a ceiling flag after 3 px -> kid_t = 554, vy = 0.
REQ-031 Fall-out: no floor, kid_b reaches 599 -> fell pulses, kid_l = 40, kid_t = 557 after FIN.
REQ-032 Overrun and reset: a frame_tick during H_CHK -> overrun pulse and position unchanged by the extra tick; rst_n low mid-V_SETTLE -> all outputs at reset values within the same cycle.
